// File: rtl/noc_link_pkg.sv
// Shared definitions for the NoC link sender: flit field positions and framing states.
// Flit layout, MSB first: valid, head, tail, vc id, dest, payload.
package noc_link_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BODY = 1'b1
   } frame_state_t;

   function automatic int valid_pos(input int width_noc);
      return width_noc - 1;
   endfunction

   function automatic int head_pos(input int width_noc);
      return width_noc - 2;
   endfunction

   function automatic int tail_pos(input int width_noc);
      return width_noc - 3;
   endfunction

   function automatic int vc_lsb(input int width_noc, input int vc_w);
      return width_noc - 3 - vc_w;
   endfunction

   function automatic int dest_lsb(input int width_noc, input int vc_w, input int addr_w);
      return width_noc - 3 - vc_w - addr_w;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer with wrap-around and
// moves the pointer just past the winner after every grant.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_any
);

   logic [IDX_W-1:0] ptr;

   always_comb begin
      int idx;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!grant_any && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = IDX_W'(idx);
            grant_any  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
      end else if (grant_any) begin
         if (int'(grant_idx) == NUM_REQ - 1) ptr <= '0;
         else                                ptr <= grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/noc_vc_link_sender.sv
// Credit-flow-controlled NoC link transmitter: round-robin over per-VC local
// streams, one registered flit per cycle, per-VC credit and framing tracking.
module noc_vc_link_sender
   import noc_link_pkg::*;
#(
   parameter int WIDTH_NOC        = 8,
   parameter int N                = 16,
   parameter int NUM_VC           = 2,
   parameter int DEPTH_PER_VC     = 8,
   parameter int ADDRESS_WIDTH    = $clog2(N),
   parameter int VC_ADDRESS_WIDTH = $clog2(NUM_VC)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_VC*WIDTH_NOC-1:0] i_data_in,
   input  logic [NUM_VC-1:0]           i_valid_in,
   output logic [NUM_VC-1:0]           o_ready_out,
   output logic [WIDTH_NOC-1:0]        noc_flit_out,
   input  logic [NUM_VC-1:0]           noc_credits_in,
   output logic                        o_error
);

   localparam int VALID_POS = valid_pos(WIDTH_NOC);
   localparam int HEAD_POS  = head_pos(WIDTH_NOC);
   localparam int TAIL_POS  = tail_pos(WIDTH_NOC);
   localparam int VC_LSB    = vc_lsb(WIDTH_NOC, VC_ADDRESS_WIDTH);
   localparam int DEST_LSB  = dest_lsb(WIDTH_NOC, VC_ADDRESS_WIDTH, ADDRESS_WIDTH);
   localparam int CW        = $clog2(DEPTH_PER_VC + 1);
   localparam int IDX_W     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
   localparam logic [CW-1:0] CREDIT_FULL = CW'(DEPTH_PER_VC);

   if (DEST_LSB < 0) begin : g_bad_layout
      $error("flit too narrow for header fields");
   end

   logic [NUM_VC-1:0]    eligible;
   logic [NUM_VC-1:0]    req;
   logic [NUM_VC-1:0]    grant;
   logic [NUM_VC-1:0]    overflow;
   logic [NUM_VC-1:0]    frame_err;
   logic [IDX_W-1:0]     grant_idx;
   logic                 vld_p0;
   logic [WIDTH_NOC-1:0] flit_p0;
   logic [WIDTH_NOC-1:0] flit_p1;
   logic                 error_q;

   for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      logic [CW-1:0] credit_q;
      frame_state_t  state_q;
      frame_state_t  state_d;
      logic          err_d;
      logic          send;
      logic          cred;
      logic          head;
      logic          tail;

      assign send = grant[v];
      assign cred = noc_credits_in[v];
      assign head = i_data_in[v*WIDTH_NOC + HEAD_POS];
      assign tail = i_data_in[v*WIDTH_NOC + TAIL_POS];

      // A credit pulse lands in the register, so eligibility follows one cycle later.
      assign eligible[v] = i_valid_in[v] && (credit_q != '0);
      assign overflow[v] = cred && !send && (credit_q == CREDIT_FULL);

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            credit_q <= CREDIT_FULL;
         end else if (send && !cred) begin
            credit_q <= credit_q - 1'b1;
         end else if (!send && cred && (credit_q != CREDIT_FULL)) begin
            credit_q <= credit_q + 1'b1;
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) state_q <= IDLE;
         else      state_q <= state_d;
      end

      // Malformed framing is flagged but the flit still goes out and the FSM resyncs.
      always_comb begin
         state_d = state_q;
         err_d   = 1'b0;
         if (send) begin
            if (head) begin
               state_d = tail ? IDLE : BODY;
               err_d   = (state_q == BODY);
            end else if (state_q == BODY) begin
               state_d = tail ? IDLE : BODY;
            end else begin
               err_d = 1'b1;
            end
         end
      end

      assign frame_err[v] = err_d;
   end

   assign req = eligible & {NUM_VC{rst}};

   rr_arbiter #(
      .NUM_REQ (NUM_VC),
      .IDX_W   (IDX_W)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (vld_p0)
   );

   assign o_ready_out = grant;

   // p0: select winner, force valid, stamp winning VC id
   always_comb begin
      flit_p0            = i_data_in[int'(grant_idx)*WIDTH_NOC +: WIDTH_NOC];
      flit_p0[VALID_POS] = 1'b1;
      for (int b = 0; b < VC_ADDRESS_WIDTH; b++) begin
         flit_p0[VC_LSB + b] = grant_idx[b];
      end
   end

   // p1: link register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        flit_p1 <= '0;
      else if (vld_p0) flit_p1 <= flit_p0;
      else             flit_p1 <= '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                          error_q <= 1'b0;
      else if (|overflow || |frame_err)  error_q <= 1'b1;
   end

   assign noc_flit_out = flit_p1;
   assign o_error      = error_q;

endmodule
